// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_NOP6  = 3'd6,
    MDU_NOP7  = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mdu_state_t;

  localparam int unsigned MDU_ITERS = `WORD_SIZE;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, div_i};
    // The top bit of diff is the borrow: clear means the divisor fit.
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with single-cycle MTHI/MTLO.
// MDU_FAST_MULT_EN selects a one-cycle combinational multiply for MULT/MULTU.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_ITERS,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mag_q, ph_q, pl_q, hi_q, lo_q;
  logic             neg_q, rneg_q, bzero_q, is_div_q, done_q;

  logic             is_mul_op, is_div_op, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_mul_op = (op == MDU_MULT) || (op == MDU_MULTU);
  assign is_div_op = (op == MDU_DIV)  || (op == MDU_DIVU);
  assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign a_neg     = is_signed & src_a[WIDTH-1];
  assign b_neg     = is_signed & src_b[WIDTH-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;

  // ph/pl hold {product hi, multiplier} for multiply, {remainder, dividend/quotient} for divide.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] div_rem, div_quo, ph_d, pl_d;

  assign mul_sum = {1'b0, ph_q} + (pl_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (ph_q),
    .quo_i (pl_q),
    .div_i (mag_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  assign ph_d = is_div_q ? div_rem : mul_sum[WIDTH:1];
  assign pl_d = is_div_q ? div_quo : {mul_sum[0], pl_q[WIDTH-1:1]};

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, res_hi, res_lo;

  always_comb begin
    prod_s = neg_q ? -{ph_q, pl_q} : {ph_q, pl_q};
    quo_s  = bzero_q ? '1 : (neg_q ? -pl_q : pl_q);
    rem_s  = rneg_q ? -ph_q : ph_q;
    res_hi = is_div_q ? rem_s : prod_s[2*WIDTH-1:WIDTH];
    res_lo = is_div_q ? quo_s : prod_s[WIDTH-1:0];
  end

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;

  always_comb begin
    ext_a     = {{WIDTH{a_neg}}, src_a};
    ext_b     = {{WIDTH{b_neg}}, src_b};
    fast_prod = ext_a * ext_b;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mag_q    <= '0;
      ph_q     <= '0;
      pl_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !flush) begin
            if (is_mul_op || is_div_op) begin
              mag_q    <= is_div_op ? b_mag : a_mag;
              ph_q     <= '0;
              pl_q     <= is_div_op ? a_mag : b_mag;
              neg_q    <= a_neg ^ b_neg;
              rneg_q   <= a_neg;
              bzero_q  <= (src_b == '0);
              is_div_q <= is_div_op;
              cnt_q    <= '0;
              state_q  <= RUN;
`ifdef MDU_FAST_MULT_EN
              if (is_mul_op) begin
                hi_q    <= fast_prod[2*WIDTH-1:WIDTH];
                lo_q    <= fast_prod[WIDTH-1:0];
                done_q  <= 1'b1;
                state_q <= DONE;
              end
`endif
            end else if (op == MDU_MTHI) begin
              hi_q <= src_a;
            end else if (op == MDU_MTLO) begin
              lo_q <= src_a;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_W'(WIDTH)) begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            ph_q  <= ph_d;
            pl_q  <= pl_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases plus random ops against an arithmetic model.
module tb_mdu_hilo;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = 3'd7;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  mdu_hilo #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] p;
    longint      sp;
    p = '0;
    eh = '0;
    el = '0;
    case (o)
      MDU_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        p  = sp;
        eh = p[63:32];
        el = p[31:0];
      end
      MDU_MULTU: begin
        p  = {32'b0, a} * {32'b0, b};
        eh = p[63:32];
        el = p[31:0];
      end
      MDU_DIV: begin
        if (b == 0) begin
          el = '1;
          eh = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          el = a;
          eh = '0;
        end else begin
          el = $signed(a) / $signed(b);
          eh = $signed(a) % $signed(b);
        end
      end
      default: begin
        if (b == 0) begin
          el = '1;
          eh = a;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input bit intrude);
    int lat;
    int busy_cnt;
    int exp_lat;
    exp_lat = 33;
`ifdef MDU_FAST_MULT_EN
    if (o == MDU_MULT || o == MDU_MULTU) exp_lat = 0;
`endif
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd7;
    lat = 0;
    busy_cnt = 0;
    while (1) begin
      if (busy) busy_cnt++;
      if (done) break;
      if (lat >= 100) break;
      if (intrude && lat == 5) begin
        start = 1'b1;
        op    = MDU_DIVU;
        src_a = 32'h0000_0077;
        src_b = 32'h0000_0003;
      end else begin
        start = 1'b0;
        op    = 3'd7;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat + 1));
    @(posedge clk);
    #1;
    chk({tag, "_busy_after"}, 64'(busy), 64'(0));
    chk({tag, "_done_after"}, 64'(done), 64'(0));
    chk({tag, "_hi_hold"}, 64'(hi), 64'(eh));
    cur_hi = eh;
    cur_lo = el;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb, reh, rel;
    int          pulses;

    // Reset state
    #2;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases
    run_op("multu_ff_x2", MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op("mult_m3_x5", MDU_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_by0", MDU_DIVU, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("div_neg_by0", MDU_DIV, 32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b0);

    // MTHI then MTLO on consecutive cycles
    @(negedge clk);
    start = 1'b1;
    op    = MDU_MTHI;
    src_a = 32'h1234_5678;
    @(posedge clk);
    #1;
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_busy", 64'(busy), 64'(0));
    op    = MDU_MTLO;
    src_a = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd7;
    chk("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
    chk("mtlo_hi_kept", 64'(hi), 64'h1234_5678);
    chk("mtlo_busy", 64'(busy), 64'(0));
    chk("mtlo_done", 64'(done), 64'(0));
    cur_hi = 32'h1234_5678;
    cur_lo = 32'h9ABC_DEF0;

    // Undefined op and flush-with-start are both no-ops in IDLE
    @(negedge clk);
    start = 1'b1;
    op    = 3'd6;
    src_a = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    op    = MDU_MTHI;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'd7;
    chk("nop_flush_hi", 64'(hi), 64'(cur_hi));
    chk("nop_flush_lo", 64'(lo), 64'(cur_lo));
    chk("nop_flush_busy", 64'(busy), 64'(0));

    // Second start during a running MULT is ignored
    run_op("mult_intrude", MDU_MULT, 32'h0000_1234, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_DB98, 1'b1);

    // Flush mid-divide leaves HI/LO untouched and never pulses done
    @(negedge clk);
    start = 1'b1;
    op    = MDU_DIVU;
    src_a = 32'd100;
    src_b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd7;
    repeat (9) @(posedge clk);
    #1;
    chk("flush_pre_busy", 64'(busy), 64'(1));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_done", 64'(done), 64'(0));
    chk("flush_hi", 64'(hi), 64'(cur_hi));
    chk("flush_lo", 64'(lo), 64'(cur_lo));
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("flush_no_done", 64'(pulses), 64'(0));

    // Asynchronous reset mid-run clears everything immediately
    @(negedge clk);
    start = 1'b1;
    op    = MDU_DIV;
    src_a = 32'h0000_1000;
    src_b = 32'h0000_0003;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd7;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_hi", 64'(hi), 64'(0));
    chk("arst_lo", 64'(lo), 64'(0));
    cur_hi = '0;
    cur_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;

    run_op("multu_fast_case", MDU_MULTU, 32'h0000_FFFF, 32'h0001_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);

    // Random operations against the reference model
    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(3, 0));
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = $urandom_range(15, 0);
      if (i == 7) rb = '0;
      if (i == 11) ra = $urandom_range(50, 0);
      model(ro, ra, rb, reh, rel);
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, reh, rel, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
